// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter:
// FSM state encoding, owner codes and bus widths.
package mem_port_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_I    = 2'd1;
   localparam logic [1:0] OWNER_D    = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// at_max tells the arbiter that fetch must win the next arbitration.
module arb_starve_counter #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] count;

   // Clear wins over increment; the count holds once it reaches MAX.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != MAX_V)) begin
         count <= count + 1'b1;
      end
   end

   assign at_max = (count == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory between instruction fetch
// and data load/store. Data has priority; a starvation limit forces a
// fetch grant and a timeout aborts accesses to a memory that never answers.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              bus_err
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [1:0]        state;
   logic [1:0]        owner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wr_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [TW-1:0]     tmo_cnt;

   logic starve_at_max;
   logic grant_d;
   logic grant_i;
   logic in_idle;
   logic starve_inc;
   logic starve_clr;

   // Winner selection in IDLE: data first unless fetch has starved long enough.
   always_comb begin
      in_idle    = (state == ST_IDLE);
      grant_i    = in_idle && i_req && (!d_req || starve_at_max);
      grant_d    = in_idle && d_req && !grant_i;
      starve_inc = grant_d && i_req;
      starve_clr = grant_i || (in_idle && !i_req);
   end

   arb_starve_counter #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk    (clk),
      .rst    (rst),
      .inc    (starve_inc),
      .clr    (starve_clr),
      .at_max (starve_at_max)
   );

   // Main FSM: latch the winner's request, wait for memory or timeout,
   // then present one response cycle to the latched owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         owner   <= OWNER_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_d || grant_i) begin
                  owner   <= grant_d ? OWNER_D : OWNER_I;
                  addr_q  <= grant_d ? d_addr : i_addr;
                  wdata_q <= grant_d ? d_wdata : '0;
                  wr_q    <= grant_d && d_wr;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ready) begin
                  rdata_q <= wr_q ? '0 : mem_rdata;
                  err_q   <= 1'b0;
                  state   <= ST_RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               owner   <= OWNER_NONE;
               err_q   <= 1'b0;
               rdata_q <= '0;
               state   <= ST_IDLE;
            end
            default: begin
               owner <= OWNER_NONE;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from registered state; everything is zero outside
   // the cycles where it is meaningful.
   always_comb begin
      mem_req   = (state == ST_BUSY);
      mem_wr    = mem_req && wr_q;
      mem_addr  = mem_req ? addr_q : '0;
      mem_wdata = mem_req ? wdata_q : '0;
      i_ack     = (state == ST_RESP) && (owner == OWNER_I);
      d_ack     = (state == ST_RESP) && (owner == OWNER_D);
      i_rdata   = i_ack ? rdata_q : '0;
      d_rdata   = d_ack ? rdata_q : '0;
      bus_err   = (state == ST_RESP) && err_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset, fetch/data accesses,
// priority, starvation limit, store path and bus timeout.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        bus_err;

   int total;
   int bad;

   mem_port_arbiter #(
      .STARVE_MAX (4),
      .TIMEOUT    (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .bus_err   (bus_err)
   );

   // 10 ns free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_outs"},
                   {25'd0, i_ack, d_ack, mem_req, mem_wr, bus_err, 2'b00}, 32'd0);
      check_output({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
      check_output({tag, "_mbus"}, mem_addr | mem_wdata, 32'd0);
   endtask

   // Linear sequence of directed steps with hand-computed expectations.
   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      i_req     = 1'b0;
      i_addr    = 32'd0;
      d_req     = 1'b0;
      d_wr      = 1'b0;
      d_addr    = 32'd0;
      d_wdata   = 32'd0;
      mem_rdata = 32'd0;
      mem_ready = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;

      // 1) reset while an access is in flight
      $display("[TB] step 1: reset mid-BUSY");
      d_req  = 1'b1;
      d_addr = 32'h0000_0010;
      tick();
      check_output("t1_busy_mem_req", {31'd0, mem_req}, 32'd1);
      tick();
      check_output("t1_busy2_mem_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      check_output("t1_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_output("t1_rst_d_ack", {31'd0, d_ack}, 32'd0);
      rst   = 1'b0;
      d_req = 1'b0;
      tick();
      check_all_zero("t1_after");
      tick();
      check_output("t1_no_late_ack", {31'd0, d_ack}, 32'd0);

      // 2) single fetch, memory ready on the first BUSY cycle
      $display("[TB] step 2: single fetch");
      i_req     = 1'b1;
      i_addr    = 32'h0000_0040;
      mem_ready = 1'b1;
      mem_rdata = 32'h8C22_0004;
      check_output("t2_idle_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
      check_output("t2_busy_mem_req", {31'd0, mem_req}, 32'd1);
      check_output("t2_busy_addr", mem_addr, 32'h0000_0040);
      check_output("t2_busy_wr", {31'd0, mem_wr}, 32'd0);
      check_output("t2_busy_no_ack", {31'd0, i_ack}, 32'd0);
      tick();
      check_output("t2_i_ack", {31'd0, i_ack}, 32'd1);
      check_output("t2_i_rdata", i_rdata, 32'h8C22_0004);
      check_output("t2_d_ack", {31'd0, d_ack}, 32'd0);
      check_output("t2_resp_mem_req", {31'd0, mem_req}, 32'd0);
      i_req = 1'b0;
      tick();
      check_output("t2_ack_pulse", {31'd0, i_ack}, 32'd0);
      check_output("t2_rdata_cleared", i_rdata, 32'd0);

      // 3) simultaneous fetch and load: data first, then fetch
      $display("[TB] step 3: simultaneous requests");
      i_req     = 1'b1;
      i_addr    = 32'h0000_0044;
      d_req     = 1'b1;
      d_wr      = 1'b0;
      d_addr    = 32'h0000_0100;
      mem_rdata = 32'h1111_2222;
      tick();
      check_output("t3_data_first_addr", mem_addr, 32'h0000_0100);
      tick();
      check_output("t3_d_ack", {31'd0, d_ack}, 32'd1);
      check_output("t3_d_rdata", d_rdata, 32'h1111_2222);
      check_output("t3_i_ack_none", {31'd0, i_ack}, 32'd0);
      check_output("t3_i_rdata_none", i_rdata, 32'd0);
      d_req = 1'b0;
      tick();
      check_output("t3_gap_mem_req", {31'd0, mem_req}, 32'd0);
      mem_rdata = 32'h3333_4444;
      tick();
      check_output("t3_fetch_addr", mem_addr, 32'h0000_0044);
      check_output("t3_fetch_mem_req", {31'd0, mem_req}, 32'd1);
      tick();
      check_output("t3_i_ack", {31'd0, i_ack}, 32'd1);
      check_output("t3_i_rdata", i_rdata, 32'h3333_4444);
      i_req = 1'b0;
      tick();

      // 4) starvation limit: four data grants, then fetch is forced
      $display("[TB] step 4: starvation limit");
      i_req  = 1'b1;
      i_addr = 32'h0000_0080;
      d_req  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         d_addr    = 32'h0000_0300 + 32'(k * 4);
         mem_rdata = 32'hA000_0000 + 32'(k);
         tick();
         check_output($sformatf("t4_data%0d_addr", k), mem_addr, 32'h0000_0300 + 32'(k * 4));
         tick();
         check_output($sformatf("t4_data%0d_ack", k), {30'd0, i_ack, d_ack}, 32'd1);
         check_output($sformatf("t4_data%0d_rdata", k), d_rdata, 32'hA000_0000 + 32'(k));
         tick();
      end
      d_addr    = 32'h0000_0310;
      mem_rdata = 32'h0BAD_F00D;
      tick();
      check_output("t4_forced_fetch_addr", mem_addr, 32'h0000_0080);
      tick();
      check_output("t4_forced_fetch_ack", {30'd0, i_ack, d_ack}, 32'd2);
      check_output("t4_forced_fetch_rdata", i_rdata, 32'h0BAD_F00D);
      i_addr = 32'h0000_0084;
      tick();
      tick();
      check_output("t4_cnt_cleared_data_wins", mem_addr, 32'h0000_0310);
      tick();
      check_output("t4_cnt_cleared_ack", {30'd0, i_ack, d_ack}, 32'd1);
      i_req = 1'b0;
      d_req = 1'b0;
      tick();

      // 5) store with mem_ready after five wait cycles
      $display("[TB] step 5: store");
      d_req     = 1'b1;
      d_wr      = 1'b1;
      d_addr    = 32'h0000_0200;
      d_wdata   = 32'hDEAD_BEEF;
      mem_ready = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      for (int k = 0; k < 5; k++) begin
         check_output($sformatf("t5_wait%0d_ctl", k), {30'd0, mem_req, mem_wr}, 32'd3);
         check_output($sformatf("t5_wait%0d_addr", k), mem_addr, 32'h0000_0200);
         check_output($sformatf("t5_wait%0d_wdata", k), mem_wdata, 32'hDEAD_BEEF);
         check_output($sformatf("t5_wait%0d_no_ack", k), {31'd0, d_ack}, 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      check_output("t5_ready_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      check_output("t5_d_ack", {31'd0, d_ack}, 32'd1);
      check_output("t5_d_rdata_zero", d_rdata, 32'd0);
      check_output("t5_no_bus_err", {31'd0, bus_err}, 32'd0);
      d_req     = 1'b0;
      d_wr      = 1'b0;
      mem_ready = 1'b0;
      tick();

      // 6) memory never answers: abort after sixteen BUSY cycles
      $display("[TB] step 6: bus timeout");
      d_req     = 1'b1;
      d_addr    = 32'h0000_0400;
      mem_rdata = 32'h5555_AAAA;
      tick();
      for (int k = 0; k < 16; k++) begin
         check_output($sformatf("t6_busy%0d", k), {29'd0, mem_req, d_ack, bus_err}, 32'd4);
         tick();
      end
      check_output("t6_abort_ack_err", {29'd0, mem_req, d_ack, bus_err}, 32'd3);
      check_output("t6_abort_rdata", d_rdata, 32'd0);
      d_req = 1'b0;
      tick();
      check_all_zero("t6_idle");
      tick();
      check_output("t6_stays_idle", {31'd0, mem_req}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
